// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - forwarding-select encodings shared by the hazard scoreboard files
package hazard_scoreboard_pkg;

   localparam int SEL_RF = 0;

   function automatic int sel_stg(input int k);
      return k + 1;
   endfunction

   function automatic int sel_long(input int num_fwd);
      return num_fwd + 1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_match.sv
// rtl/hazard_scoreboard_fwd_match.sv - priority bypass match for one EX source operand
module hazard_scoreboard_fwd_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_FWD = 2,
   parameter int RA_W    = 5,
   parameter int SEL_W   = 2
) (
   input  logic [RA_W-1:0]         src,
   input  logic [NUM_FWD*RA_W-1:0] stg_rd,
   input  logic [NUM_FWD-1:0]      stg_wen,
   input  logic                    lw_valid,
   input  logic [RA_W-1:0]         lw_rd,
   output logic [SEL_W-1:0]        sel
);

   // Walk from the oldest stage down so the nearest (lowest k) match is written last and wins.
   always_comb begin
      sel = SEL_W'(SEL_RF);
      if (src != '0) begin
         if (lw_valid && lw_rd == src)
            sel = SEL_W'(sel_long(NUM_FWD));
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (stg_wen[k] && stg_rd[k*RA_W +: RA_W] == src)
               sel = SEL_W'(sel_stg(k));
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding, load-use and long-op busy scoreboard with pipeline stall
// Optional stall/forward statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int NUM_SRC = 3,
   parameter  int NUM_FWD = 2,
   parameter  int RA_W    = 5,
   localparam int SEL_W   = $clog2(NUM_FWD + 2),
   localparam int NREG    = 2 ** RA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [NUM_SRC*RA_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]      id_rs_used,
   input  logic [RA_W-1:0]         id_rd,
   input  logic                    id_wen,
   input  logic                    id_long,
   input  logic [NUM_SRC*RA_W-1:0] ex_rs,
   input  logic [RA_W-1:0]         ex_rd,
   input  logic                    ex_is_load,
   input  logic [NUM_FWD*RA_W-1:0] stg_rd,
   input  logic [NUM_FWD-1:0]      stg_wen,
   input  logic [RA_W-1:0]         me_rs2,
   input  logic                    me_mem_write,
   input  logic                    lw_valid,
   input  logic [RA_W-1:0]         lw_rd,
   input  logic                    flush,
   output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
   output logic                    fwd_store,
   output logic                    stall,
`ifdef HAZARD_STATS_EN
   output logic [31:0]             stat_stall_cyc,
   output logic [31:0]             stat_lu_cyc,
   output logic [31:0]             stat_fwd_cnt,
`endif
   output logic [NREG-1:0]         sb_busy
);

   logic [NREG-1:0]          busy;
   logic [NREG-1:0]          set_vec;
   logic [NREG-1:0]          clr_vec;
   logic [NUM_SRC*SEL_W-1:0] sel_raw;
   logic                     store_match;
   logic                     lu;
   logic                     raw;
   logic                     waw;
   logic                     hazard;
   logic                     issue;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      hazard_scoreboard_fwd_match #(
         .NUM_FWD (NUM_FWD),
         .RA_W    (RA_W),
         .SEL_W   (SEL_W)
      ) u_match (
         .src      (ex_rs[g*RA_W +: RA_W]),
         .stg_rd   (stg_rd),
         .stg_wen  (stg_wen),
         .lw_valid (lw_valid),
         .lw_rd    (lw_rd),
         .sel      (sel_raw[g*SEL_W +: SEL_W])
      );
   end

   assign store_match = me_mem_write && stg_wen[NUM_FWD-1] &&
                        stg_rd[(NUM_FWD-1)*RA_W +: RA_W] == me_rs2 && me_rs2 != '0;

   // A writeback landing this cycle releases a busy register, so it must not stall.
   always_comb begin
      lu  = 1'b0;
      raw = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs_used[i]) begin
            if (ex_is_load && ex_rd != '0 && ex_rd == id_rs[i*RA_W +: RA_W])
               lu = 1'b1;
            if (busy[id_rs[i*RA_W +: RA_W]] && !(lw_valid && lw_rd == id_rs[i*RA_W +: RA_W]))
               raw = 1'b1;
         end
      end
   end

   assign waw    = id_wen && busy[id_rd] && !(lw_valid && lw_rd == id_rd);
   assign hazard = id_valid && !flush && (lu || raw || waw);
   assign issue  = id_valid && id_wen && id_long && !hazard && !flush && id_rd != '0;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue)
         set_vec[id_rd] = 1'b1;
      if (lw_valid)
         clr_vec[lw_rd] = 1'b1;
   end

   // OR-ing the set after the clear lets a new producer win over a same-cycle release.
   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else
         busy <= ((busy & ~clr_vec) | set_vec) & ~NREG'(1);
   end

   assign fwd_sel   = rst ? '0 : sel_raw;
   assign fwd_store = !rst && store_match;
   assign stall     = !rst && hazard;
   assign sb_busy   = busy;

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cyc <= '0;
         stat_lu_cyc    <= '0;
         stat_fwd_cnt   <= '0;
      end else begin
         if (hazard && stat_stall_cyc != '1)
            stat_stall_cyc <= stat_stall_cyc + 32'd1;
         if (hazard && lu && stat_lu_cyc != '1)
            stat_lu_cyc <= stat_lu_cyc + 32'd1;
         if (|sel_raw && stat_fwd_cnt != '1)
            stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vectors for hazard_scoreboard
// Stats checks are included when HAZARD_STATS_EN is defined.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [14:0] id_rs;
   logic [2:0]  id_rs_used;
   logic [4:0]  id_rd;
   logic        id_wen;
   logic        id_long;
   logic [14:0] ex_rs;
   logic [4:0]  ex_rd;
   logic        ex_is_load;
   logic [9:0]  stg_rd;
   logic [1:0]  stg_wen;
   logic [4:0]  me_rs2;
   logic        me_mem_write;
   logic        lw_valid;
   logic [4:0]  lw_rd;
   logic        flush;
   logic [5:0]  fwd_sel;
   logic        fwd_store;
   logic        stall;
   logic [31:0] sb_busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] stat_stall_cyc;
   logic [31:0] stat_lu_cyc;
   logic [31:0] stat_fwd_cnt;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_wen       (id_wen),
      .id_long      (id_long),
      .ex_rs        (ex_rs),
      .ex_rd        (ex_rd),
      .ex_is_load   (ex_is_load),
      .stg_rd       (stg_rd),
      .stg_wen      (stg_wen),
      .me_rs2       (me_rs2),
      .me_mem_write (me_mem_write),
      .lw_valid     (lw_valid),
      .lw_rd        (lw_rd),
      .flush        (flush),
      .fwd_sel      (fwd_sel),
      .fwd_store    (fwd_store),
      .stall        (stall),
`ifdef HAZARD_STATS_EN
      .stat_stall_cyc (stat_stall_cyc),
      .stat_lu_cyc    (stat_lu_cyc),
      .stat_fwd_cnt   (stat_fwd_cnt),
`endif
      .sb_busy      (sb_busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic idle();
      id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_wen = 0; id_long = 0;
      ex_rs = '0; ex_rd = '0; ex_is_load = 0; stg_rd = '0; stg_wen = '0;
      me_rs2 = '0; me_mem_write = 0; lw_valid = 0; lw_rd = '0; flush = 0;
   endtask

   task automatic issue_long(input logic [4:0] rd);
      idle();
      id_valid = 1; id_wen = 1; id_long = 1; id_rd = rd;
   endtask

   task automatic read_src0(input logic [4:0] rs);
      idle();
      id_valid = 1; id_rs = {10'd0, rs}; id_rs_used = 3'b001;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      // forwarding and stall forced low while in reset
      ex_rs = {10'd0, 5'd5}; stg_rd = {5'd5, 5'd5}; stg_wen = 2'b11;
      settle();
      chk("rst_fwd_sel", fwd_sel, 6'd0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_busy", sb_busy, 32'd0);

      tick(); rst = 0;
      // 1: bypass priority
      ex_rs = {10'd0, 5'd5}; stg_rd = {5'd5, 5'd5}; stg_wen = 2'b11;
      settle(); chk("fwd_nearest", fwd_sel, 6'd1);
      tick(); stg_wen = 2'b10;
      settle(); chk("fwd_stage1", fwd_sel, 6'd2);
      tick(); stg_wen = 2'b00;
      settle(); chk("fwd_none", fwd_sel, 6'd0);
      tick(); lw_valid = 1; lw_rd = 5; ex_rs = {5'd5, 5'd0, 5'd5};
      settle(); chk("fwd_long", fwd_sel, 6'h33);
      tick(); idle(); stg_rd = '0; stg_wen = 2'b11; lw_valid = 1; lw_rd = 0;
      settle(); chk("fwd_x0", fwd_sel, 6'd0);

      // 2: load-use
      tick(); idle();
      ex_is_load = 1; ex_rd = 7; id_valid = 1; id_rs = {5'd0, 5'd7, 5'd0}; id_rs_used = 3'b010;
      settle(); chk("lu_stall", stall, 1'b1);
      tick(); ex_is_load = 0; ex_rd = 0;
      settle(); chk("lu_one_bubble", stall, 1'b0);
      tick(); ex_is_load = 1; ex_rd = 7; id_rs_used = 3'b001;
      settle(); chk("lu_unused", stall, 1'b0);
      tick(); id_rs_used = 3'b010; flush = 1;
      settle(); chk("lu_flush", stall, 1'b0);

      // 3: busy RAW and release
      tick(); issue_long(9);
      settle(); chk("issue_nostall", stall, 1'b0);
      tick(); read_src0(9);
      settle();
      chk("busy9_set", sb_busy, 32'h200);
      chk("raw_stall", stall, 1'b1);
      tick();
      settle(); chk("raw_hold", stall, 1'b1);
      tick(); lw_valid = 1; lw_rd = 9;
      settle(); chk("raw_release", stall, 1'b0);
      tick(); lw_valid = 0;
      settle();
      chk("busy9_clr", sb_busy, 32'd0);
      chk("raw_after", stall, 1'b0);

      // WAW on a busy destination
      tick(); issue_long(9);
      tick(); idle(); id_valid = 1; id_wen = 1; id_rd = 9;
      settle(); chk("waw_stall", stall, 1'b1);

      // 4: same-cycle set and clear keeps the register busy
      tick(); issue_long(9); lw_valid = 1; lw_rd = 9;
      settle(); chk("setclr_nostall", stall, 1'b0);
      tick(); idle();
      settle(); chk("setclr_busy", sb_busy, 32'h200);
      tick(); lw_valid = 1; lw_rd = 9;
      tick(); idle();
      // lw_valid to a non-busy register is harmless
      lw_valid = 1; lw_rd = 12;
      tick(); idle();
      settle(); chk("busy_empty", sb_busy, 32'd0);

      // 5: long op to x0 and store-data forwarding
      tick(); issue_long(0);
      tick(); idle();
      settle(); chk("x0_never_busy", sb_busy, 32'd0);
      tick(); me_mem_write = 1; me_rs2 = 3; stg_rd = {5'd3, 5'd0}; stg_wen = 2'b10;
      settle(); chk("fwd_store", fwd_store, 1'b1);
      tick(); stg_rd = {5'd0, 5'd3}; stg_wen = 2'b01;
      settle(); chk("fwd_store_stg0", fwd_store, 1'b0);
      tick(); me_rs2 = 0; stg_rd = '0; stg_wen = 2'b10;
      settle(); chk("fwd_store_x0", fwd_store, 1'b0);

      // 6: reset clears busy and stall
      tick(); issue_long(4);
      tick(); issue_long(6);
      tick(); read_src0(4);
      settle();
      chk("pre_rst_busy", sb_busy, 32'h50);
      chk("pre_rst_stall", stall, 1'b1);
      tick(); rst = 1;
      settle(); chk("in_rst_stall", stall, 1'b0);
      tick(); rst = 0;
      settle();
      chk("post_rst_busy", sb_busy, 32'd0);
      chk("post_rst_stall", stall, 1'b0);

`ifdef HAZARD_STATS_EN
      tick(); idle(); rst = 1;
      tick(); rst = 0; issue_long(10);
      tick(); read_src0(10);
      tick();
      tick();
      tick(); idle(); lw_valid = 1; lw_rd = 10;
      tick(); idle(); ex_is_load = 1; ex_rd = 7; id_valid = 1; id_rs = {10'd0, 5'd7}; id_rs_used = 3'b001;
      tick(); idle(); ex_rs = {10'd0, 5'd2}; stg_rd = {5'd0, 5'd2}; stg_wen = 2'b01;
      tick(); idle();
      settle();
      chk("stat_stall_cyc", stat_stall_cyc, 32'd4);
      chk("stat_lu_cyc", stat_lu_cyc, 32'd1);
      chk("stat_fwd_cnt", stat_fwd_cnt, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
